mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath. Decodes opcode[5:0] and
//  sequences fetch/decode/execute/memory/writeback, driving the 2-bit ALU_op
//  consumed by ALU_Control plus all mux selects and register/memory write
//  enables. Waits on the memory ready handshake, with a watchdog timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles to wait for mem_ready before aborting (>=2)
//  CNT_W        5   watchdog counter width; must hold MEM_TIMEOUT
// PORTS
//  clk            in   1  clock; all state changes on rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  opcode         in   6  IR[31:26], valid from DECODE onward
//  mem_ready      in   1  memory completes the current access this cycle
//  mem_req        out  1  memory access request, held until mem_ready/timeout
//  mem_write      out  1  access is a write (valid only with mem_req)
//  iord           out  1  0: address = PC, 1: address = ALUOut
//  ir_write       out  1  load IR from memory data
//  pc_write       out  1  unconditional PC load
//  pc_write_cond  out  1  PC load gated by ALU zero (beq)
//  pc_src         out  2  00 ALU result, 01 ALUOut, 10 jump target
//  alu_src_a      out  1  0: PC, 1: register A
//  alu_src_b      out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//  ALU_op         out  2  00 add, 01 sub, 10 use funct (to ALU_Control)
//  reg_dst        out  1  0: rt, 1: rd
//  mem_to_reg     out  1  0: ALUOut, 1: MDR
//  reg_write      out  1  register file write enable
//  illegal_op     out  1  1-cycle pulse: unsupported opcode decoded
//  bus_err        out  1  1-cycle pulse: memory watchdog expired
//  state_o        out  4  current state code (debug)
// BEHAVIOUR
//  - Moore outputs decoded from state only, except mem_req/ir_write gating.
//  - Reset (async, reset_n=0): state=FETCH, watchdog=0. Outputs while in reset
//    are all 0 (FETCH outputs are suppressed until first clk after release).
//  - Unlisted outputs are 0 in each state. Codes 0..11 as listed:
//    FETCH(0):   mem_req, iord=0, alu_src_a=0, alu_src_b=01, ALU_op=00,
//                pc_src=00; on mem_ready: ir_write=1, pc_write=1 -> DECODE.
//    DECODE(1):  alu_src_a=0, alu_src_b=11, ALU_op=00 (branch target -> ALUOut).
//                opcode 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH,
//                000010->JUMP, 001000->ADDIEX; other: illegal_op=1 -> FETCH.
//    MEMADR(2):  alu_src_a=1, alu_src_b=10, ALU_op=00; lw->MEMRD, sw->MEMWR.
//    MEMRD(3):   mem_req, iord=1; on mem_ready -> MEMWB.
//    MEMWB(4):   reg_write, reg_dst=0, mem_to_reg=1 -> FETCH.
//    MEMWR(5):   mem_req, mem_write, iord=1; on mem_ready -> FETCH.
//    EXEC(6):    alu_src_a=1, alu_src_b=00, ALU_op=10 -> ALUWB.
//    ALUWB(7):   reg_write, reg_dst=1, mem_to_reg=0 -> FETCH.
//    BRANCH(8):  alu_src_a=1, alu_src_b=00, ALU_op=01, pc_src=01,
//                pc_write_cond -> FETCH.
//    ADDIEX(9):  alu_src_a=1, alu_src_b=10, ALU_op=00 -> ADDIWB.
//    ADDIWB(10): reg_write, reg_dst=0, mem_to_reg=0 -> FETCH.
//    JUMP(11):   pc_write, pc_src=10 -> FETCH.
//    Codes 12..15 unreachable; if entered, go to FETCH next cycle, no strobes.
//  - Memory states (FETCH/MEMRD/MEMWR): watchdog clears on entry, increments
//    each cycle mem_ready=0. If mem_ready=1 in the same cycle the count reaches
//    MEM_TIMEOUT-1, mem_ready wins. Expiry: bus_err=1, drop mem_req, no
//    ir_write/pc_write/reg_write, -> FETCH (refetch, same PC).
//  - mem_ready outside memory states is ignored.
//  - Latency (zero-wait memory): R-type/addi 4 cycles, lw 5, sw 4, beq 3, j 3.
//  - Mid-operation reset: abort immediately, no write enables asserted.
// TESTING
//  1 R-type, opcode=000000, mem_ready=1: states 0,1,6,7,0; ALU_op=10 in EXEC;
//    reg_write=1, reg_dst=1 in ALUWB only.
//  2 lw 100011 with mem_ready low 3 cycles in MEMRD: 0,1,2,3,3,3,3,4,0;
//    mem_req steady; reg_write, mem_to_reg=1 in MEMWB.
//  3 beq 000100: BRANCH drives ALU_op=01, pc_src=01, pc_write_cond=1 for 1 cycle.
//  4 opcode 111111: illegal_op pulses 1 cycle in DECODE, next state FETCH.
//  5 mem_ready held 0 in FETCH: bus_err pulses after 16 cycles, ir_write and
//    pc_write never asserted, FETCH re-entered with watchdog=0.
//  6 reset_n low during MEMWR: state_o=0 and all outputs 0 asynchronously;
//    after release, normal fetch resumes.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Main control FSM for a multi-cycle MIPS datapath. It decodes opcode and
//   steps through fetch, decode, execute, memory and writeback. It drives the
//   2-bit ALU_op consumed by ALU_Control, every datapath mux select and the
//   register/memory write enables. In each memory state it waits for
//   mem_ready, and a watchdog aborts the access if memory never answers.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   opcode        IR[31:26], valid from DECODE onward
//   mem_ready     memory completes the current access this cycle
//   mem_req       memory request, held until mem_ready or watchdog expiry
//   mem_write     current access is a write (only with mem_req)
//   iord          address select: 0 PC, 1 ALUOut
//   ir_write      load IR from memory data
//   pc_write      unconditional PC load
//   pc_write_cond PC load gated by ALU zero
//   pc_src        00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a     0 PC, 1 register A
//   alu_src_b     00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   ALU_op        00 add, 01 sub, 10 use funct
//   reg_dst       0 rt, 1 rd
//   mem_to_reg    0 ALUOut, 1 MDR
//   reg_write     register file write enable
//   illegal_op    one-cycle pulse when an unsupported opcode is decoded
//   bus_err       one-cycle pulse when the memory watchdog expires
//   state_o       current state code (debug)
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ALU_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  // Held low in reset and set on the first clock after release. Every output
  // is masked while it is low, so FETCH strobes stay quiet until the FSM runs.
  logic             active_q;
  logic             mem_state;
  logic             expire;
  logic             legal_op;

  always_comb begin
    mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A ready in the last allowed cycle takes priority over expiry.
    expire    = mem_state && !mem_ready && (wd_q == WD_LAST);
    legal_op  = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

    state_d = state_q;
    case (state_q)
      S_FETCH:  if (expire) state_d = S_FETCH;
                else if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (expire) state_d = S_FETCH;
                else if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (expire || mem_ready) state_d = S_FETCH;
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase

    // Staying in a memory state always means "still waiting", and any
    // transition (including the refetch after expiry) starts from zero.
    if (mem_state && !mem_ready && !expire) wd_d = wd_q + CNT_W'(1);
    else                                    wd_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      wd_q     <= '0;
      active_q <= 1'b0;
    end else if (!active_q) begin
      active_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      wd_q     <= wd_d;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ALU_op        = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_op    = 1'b0;
    bus_err       = 1'b0;
    if (active_q) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = !expire;
          alu_src_b = 2'b01;
          ir_write  = mem_ready && !expire;
          pc_write  = mem_ready && !expire;
          bus_err   = expire;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = !legal_op;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          mem_req = !expire;
          iord    = 1'b1;
          bus_err = expire;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEMWR: begin
          mem_req   = !expire;
          mem_write = !expire;
          iord      = 1'b1;
          bus_err   = expire;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          ALU_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          ALU_op        = 2'b01;
          pc_src        = 2'b01;
          pc_write_cond = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed test of the multi-cycle MIPS control FSM. Each cycle is compared
//   against a hand-written state code and a packed output vector.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_src_b, ALU_op;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal_op, bus_err;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .iord          (iord),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ALU_op        (ALU_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .illegal_op    (illegal_op),
    .bus_err       (bus_err),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: mem_req mem_write iord ir_write pc_write pc_write_cond
  //               pc_src[1:0] alu_src_a alu_src_b[1:0] ALU_op[1:0]
  //               reg_dst mem_to_reg reg_write illegal_op bus_err
  logic [18:0] outs;
  assign outs = {mem_req, mem_write, iord, ir_write, pc_write, pc_write_cond,
                 pc_src, alu_src_a, alu_src_b, ALU_op,
                 reg_dst, mem_to_reg, reg_write, illegal_op, bus_err};

  localparam logic [18:0] O_ZERO       = 19'b0;
  localparam logic [18:0] O_FETCH_WAIT = {6'b100000, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000};
  localparam logic [18:0] O_FETCH_RDY  = {6'b100110, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00000};
  localparam logic [18:0] O_FETCH_TO   = {6'b000000, 2'b00, 1'b0, 2'b01, 2'b00, 5'b00001};
  localparam logic [18:0] O_DECODE     = {6'b000000, 2'b00, 1'b0, 2'b11, 2'b00, 5'b00000};
  localparam logic [18:0] O_DECODE_ILL = {6'b000000, 2'b00, 1'b0, 2'b11, 2'b00, 5'b00010};
  localparam logic [18:0] O_MEMADR     = {6'b000000, 2'b00, 1'b1, 2'b10, 2'b00, 5'b00000};
  localparam logic [18:0] O_MEMRD      = {6'b101000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00000};
  localparam logic [18:0] O_MEMWB      = {6'b000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b01100};
  localparam logic [18:0] O_MEMWR      = {6'b111000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00000};
  localparam logic [18:0] O_EXEC       = {6'b000000, 2'b00, 1'b1, 2'b00, 2'b10, 5'b00000};
  localparam logic [18:0] O_ALUWB      = {6'b000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b10100};
  localparam logic [18:0] O_BRANCH     = {6'b000001, 2'b01, 1'b1, 2'b00, 2'b01, 5'b00000};
  localparam logic [18:0] O_ADDIEX     = {6'b000000, 2'b00, 1'b1, 2'b10, 2'b00, 5'b00000};
  localparam logic [18:0] O_ADDIWB     = {6'b000000, 2'b00, 1'b0, 2'b00, 2'b00, 5'b00100};
  localparam logic [18:0] O_JUMP       = {6'b000010, 2'b10, 1'b0, 2'b00, 2'b00, 5'b00000};

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_ADI = 6'b001000;
  localparam logic [5:0] OP_BAD = 6'b111111;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One FSM cycle: apply inputs mid-cycle, check state and outputs, then
  // advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic mr, input logic [5:0] op,
                     input logic [3:0] es, input logic [18:0] eo);
    mem_ready = mr;
    opcode    = op;
    #1;
    $display("%s: mr=%0b op=%b state=%0d outs=%h", tag, mr, op, state_o, outs);
    check_eq({tag, " state"}, {28'd0, state_o}, {28'd0, es});
    check_eq({tag, " outs"}, {13'd0, outs}, {13'd0, eo});
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_R;
    repeat (2) @(posedge clk);
    #2;
    check_eq("reset state", {28'd0, state_o}, 32'd0);
    check_eq("reset outs", {13'd0, outs}, {13'd0, O_ZERO});
    reset_n = 1'b1;
    #1;
    check_eq("released outs", {13'd0, outs}, {13'd0, O_ZERO});
    @(posedge clk);
    #2;

    // R-type, zero-wait memory
    cyc("rtype fetch", 1'b1, OP_R, 4'd0, O_FETCH_RDY);
    cyc("rtype decode", 1'b1, OP_R, 4'd1, O_DECODE);
    cyc("rtype exec", 1'b1, OP_R, 4'd6, O_EXEC);
    cyc("rtype aluwb", 1'b1, OP_R, 4'd7, O_ALUWB);

    // lw with three wait cycles in MEMRD
    cyc("lw fetch", 1'b1, OP_LW, 4'd0, O_FETCH_RDY);
    cyc("lw decode", 1'b0, OP_LW, 4'd1, O_DECODE);
    cyc("lw memadr", 1'b0, OP_LW, 4'd2, O_MEMADR);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lw memrd wait%0d", i), 1'b0, OP_LW, 4'd3, O_MEMRD);
    cyc("lw memrd rdy", 1'b1, OP_LW, 4'd3, O_MEMRD);
    cyc("lw memwb", 1'b0, OP_LW, 4'd4, O_MEMWB);

    // sw
    cyc("sw fetch", 1'b1, OP_SW, 4'd0, O_FETCH_RDY);
    cyc("sw decode", 1'b1, OP_SW, 4'd1, O_DECODE);
    cyc("sw memadr", 1'b1, OP_SW, 4'd2, O_MEMADR);
    cyc("sw memwr", 1'b1, OP_SW, 4'd5, O_MEMWR);

    // beq
    cyc("beq fetch", 1'b1, OP_BEQ, 4'd0, O_FETCH_RDY);
    cyc("beq decode", 1'b1, OP_BEQ, 4'd1, O_DECODE);
    cyc("beq branch", 1'b1, OP_BEQ, 4'd8, O_BRANCH);

    // j
    cyc("j fetch", 1'b1, OP_J, 4'd0, O_FETCH_RDY);
    cyc("j decode", 1'b1, OP_J, 4'd1, O_DECODE);
    cyc("j jump", 1'b1, OP_J, 4'd11, O_JUMP);

    // addi
    cyc("addi fetch", 1'b1, OP_ADI, 4'd0, O_FETCH_RDY);
    cyc("addi decode", 1'b1, OP_ADI, 4'd1, O_DECODE);
    cyc("addi ex", 1'b1, OP_ADI, 4'd9, O_ADDIEX);
    cyc("addi wb", 1'b1, OP_ADI, 4'd10, O_ADDIWB);

    // illegal opcode
    cyc("ill fetch", 1'b1, OP_BAD, 4'd0, O_FETCH_RDY);
    cyc("ill decode", 1'b1, OP_BAD, 4'd1, O_DECODE_ILL);

    // FETCH watchdog: 15 waiting cycles, expiry on the 16th
    for (int i = 0; i < 15; i++)
      cyc($sformatf("to wait%0d", i), 1'b0, OP_R, 4'd0, O_FETCH_WAIT);
    cyc("to expire", 1'b0, OP_R, 4'd0, O_FETCH_TO);
    // Refetch from watchdog 0: ready in the last allowed cycle wins
    for (int i = 0; i < 15; i++)
      cyc($sformatf("refetch wait%0d", i), 1'b0, OP_J, 4'd0, O_FETCH_WAIT);
    cyc("refetch last rdy", 1'b1, OP_J, 4'd0, O_FETCH_RDY);
    cyc("refetch decode", 1'b1, OP_J, 4'd1, O_DECODE);
    cyc("refetch jump", 1'b1, OP_J, 4'd11, O_JUMP);

    // Asynchronous reset in the middle of MEMWR
    cyc("rst sw fetch", 1'b1, OP_SW, 4'd0, O_FETCH_RDY);
    cyc("rst sw decode", 1'b1, OP_SW, 4'd1, O_DECODE);
    cyc("rst sw memadr", 1'b0, OP_SW, 4'd2, O_MEMADR);
    mem_ready = 1'b0;
    #1;
    check_eq("memwr before rst", {28'd0, state_o}, 32'd5);
    reset_n = 1'b0;
    #1;
    $display("async reset: state=%0d outs=%h", state_o, outs);
    check_eq("async rst state", {28'd0, state_o}, 32'd0);
    check_eq("async rst outs", {13'd0, outs}, {13'd0, O_ZERO});
    mem_ready = 1'b1;
    @(posedge clk);
    #2;
    check_eq("held rst outs", {13'd0, outs}, {13'd0, O_ZERO});
    reset_n = 1'b1;
    #1;
    check_eq("rst release outs", {13'd0, outs}, {13'd0, O_ZERO});
    @(posedge clk);
    #2;
    cyc("post rst fetch", 1'b1, OP_R, 4'd0, O_FETCH_RDY);
    cyc("post rst decode", 1'b1, OP_R, 4'd1, O_DECODE);
    cyc("post rst exec", 1'b1, OP_R, 4'd6, O_EXEC);
    cyc("post rst aluwb", 1'b1, OP_R, 4'd7, O_ALUWB);
    cyc("post rst next", 1'b0, OP_R, 4'd0, O_FETCH_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
